// File: rtl/truth_table_checker.sv
`default_nettype none
// ============================================================================
// truth_table_checker: sweeps a 3-input DUT through all 8 vectors, checks y
// against a latched truth table. Revision 1.0
// ============================================================================
module truth_table_checker #(
  parameter int HOLD_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       y,
  output logic       x0,
  output logic       x1,
  output logic       x2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] mismatch,
  output logic [3:0] error_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] exp_q, exp_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] mismatch_q, mismatch_d;
  logic [3:0] error_count_q, error_count_d;
  logic       pass_q, pass_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      exp_q         <= 8'h00;
      idx_q         <= 3'd0;
      hold_q        <= 8'd0;
      mismatch_q    <= 8'h00;
      error_count_q <= 4'd0;
      pass_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      exp_q         <= exp_d;
      idx_q         <= idx_d;
      hold_q        <= hold_d;
      mismatch_q    <= mismatch_d;
      error_count_q <= error_count_d;
      pass_q        <= pass_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    exp_d         = exp_q;
    idx_d         = idx_q;
    hold_d        = hold_q;
    mismatch_d    = mismatch_q;
    error_count_d = error_count_q;
    pass_d        = pass_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          exp_d         = expected;
          mismatch_d    = 8'h00;
          error_count_d = 4'd0;
          pass_d        = 1'b0;
          idx_d         = 3'd0;
          hold_d        = 8'd0;
          state_d       = APPLY;
        end
      end

      APPLY: begin
        hold_d = hold_q + 8'd1;
        // y is only looked at on the last cycle of each vector's hold window
        if (hold_q == HOLD_LAST) begin
          if (y != exp_q[idx_q]) begin
            mismatch_d[idx_q] = 1'b1;
            error_count_d     = error_count_q + 4'd1;
          end
          hold_d = 8'd0;
          if (idx_q == 3'd7) begin
            pass_d  = (error_count_d == 4'd0);
            state_d = DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      DONE: begin
        idx_d   = 3'd0;
        hold_d  = 8'd0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign {x2, x1, x0} = (state_q == APPLY) ? idx_q : 3'b000;
  assign busy         = (state_q == APPLY);
  assign done         = (state_q == DONE);
  assign pass         = pass_q;
  assign mismatch     = mismatch_q;
  assign error_count  = error_count_q;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_checker.sv
`default_nettype none
// ============================================================================
// tb_truth_table_checker: table-driven runs of the checker against modelled
// DUT responses, plus reset, held-start and long-hold sequences. Revision 1.0
// ============================================================================
module tb_truth_table_checker;

  localparam int H = 4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] expected;
  logic       y;
  logic       x0, x1, x2, busy, done, pass;
  logic [7:0] mismatch;
  logic [3:0] error_count;

  logic       start20;
  logic [7:0] expected20;
  logic       y20;
  logic       x0_20, x1_20, x2_20, busy20, done20, pass20;
  logic [7:0] mismatch20;
  logic [3:0] error_count20;

  int         y_mode;
  int         run_cyc;
  logic       maj;
  int         n_cmp;
  int         n_bad;

  typedef struct {
    logic [7:0] tt;
    int         mode;
    logic [7:0] mis;
    logic [3:0] err;
    logic       ok;
  } vec_t;

  vec_t vecs[8];

  truth_table_checker #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .y(y),
    .x0(x0), .x1(x1), .x2(x2), .busy(busy), .done(done), .pass(pass),
    .mismatch(mismatch), .error_count(error_count)
  );

  truth_table_checker #(.HOLD_CYCLES(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .start(start20), .expected(expected20), .y(y20),
    .x0(x0_20), .x1(x1_20), .x2(x2_20), .busy(busy20), .done(done20), .pass(pass20),
    .mismatch(mismatch20), .error_count(error_count20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // run_cyc equals the checker's position in the sweep (hold + H*index)
  always @(posedge clk) run_cyc <= busy ? run_cyc + 1 : 0;

  // modes: 0 majority, 1 stuck-0, 2 stuck-1, 3 parity, 4 majority with glitches off-compare
  always_comb begin
    maj = (x0 & x1) | (x0 & x2) | (x1 & x2);
    case (y_mode)
      0:       y = maj;
      1:       y = 1'b0;
      2:       y = 1'b1;
      3:       y = x0 ^ x1 ^ x2;
      4:       y = ((run_cyc % H) == H - 1) ? maj : ~maj;
      default: y = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run(input logic [7:0] tt, input int mode, input logic [7:0] emis,
                     input logic [3:0] eerr, input logic eok);
    int edges;
    bit seen;
    @(negedge clk);
    expected = tt;
    y_mode   = mode;
    start    = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start    = 1'b0;
    expected = ~tt;
    chk("results_cleared", {pass, mismatch, error_count}, 13'd0);
    seen = 1'b0;
    for (int k = 0; k < 8 * H + 8; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (k < 8 * H) chk("apply_vector", {busy, x2, x1, x0}, {1'b1, 3'(k / H)});
      @(negedge clk);
      edges++;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_latency", edges, 8 * H + 1);
    chk("done_idle_outputs", {busy, x2, x1, x0}, 4'b0000);
    chk("mismatch", mismatch, emis);
    chk("error_count", error_count, eerr);
    chk("pass", pass, eok);
    @(negedge clk);
    chk("done_single_cycle", done, 1'b0);
    chk("results_held", {pass, mismatch, error_count}, {eok, emis, eerr});
  endtask

  initial begin
    bit seen;
    bit stray;
    int cnt;

    n_cmp = 0;
    n_bad = 0;
    vecs[0] = '{8'hE8, 0, 8'h00, 4'd0, 1'b1};
    vecs[1] = '{8'hE8, 1, 8'hE8, 4'd4, 1'b0};
    vecs[2] = '{8'hE8, 2, 8'h17, 4'd4, 1'b0};
    vecs[3] = '{8'h96, 3, 8'h00, 4'd0, 1'b1};
    vecs[4] = '{8'h00, 2, 8'hFF, 4'd8, 1'b0};
    vecs[5] = '{8'hFF, 2, 8'h00, 4'd0, 1'b1};
    vecs[6] = '{8'hE8, 3, 8'h7E, 4'd6, 1'b0};
    vecs[7] = '{8'hE8, 4, 8'h00, 4'd0, 1'b1};

    rst_n      = 1'b0;
    start      = 1'b0;
    expected   = 8'h00;
    y_mode     = 0;
    start20    = 1'b0;
    expected20 = 8'h00;
    y20        = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {x2, x1, x0, busy, done, pass, mismatch, error_count}, 19'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run(vecs[i].tt, vecs[i].mode, vecs[i].mis, vecs[i].err, vecs[i].ok);

    // reset beats start, and clears the held pass from the last run
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("reset_priority", {busy, pass}, 2'b00);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("reset_priority_idle", busy, 1'b0);

    // reset while vector 3 is applied
    expected = 8'hE8;
    y_mode   = 0;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrun_index3", {busy, x2, x1, x0}, 4'b1011);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrun_reset_outputs", {x2, x1, x0, busy, done, pass, mismatch, error_count}, 19'd0);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) stray = 1'b1;
    end
    chk("no_done_after_reset", 32'(stray), 32'd0);
    run(8'hE8, 0, 8'h00, 4'd0, 1'b1);

    // start held high: back-to-back runs, each with its own latched table
    @(negedge clk);
    expected = 8'hE8;
    y_mode   = 0;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    expected = 8'h00;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("held_first_done", 32'(seen), 32'd1);
    chk("held_first_result", {pass, mismatch, error_count}, {1'b1, 8'h00, 4'd0});
    seen = 1'b0;
    cnt  = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      cnt++;
      if (cnt == 5) expected = 8'hFF;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("held_second_done", 32'(seen), 32'd1);
    chk("held_done_period", cnt, 8 * H + 2);
    chk("held_second_result", {pass, mismatch, error_count}, {1'b0, 8'hE8, 4'd4});
    repeat (3) @(negedge clk);
    chk("held_released_idle", busy, 1'b0);

    // long-hold instance: each vector held 20 cycles, 160 busy cycles
    @(negedge clk);
    start20 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start20 = 1'b0;
    for (int k = 0; k < 160; k++) begin
      chk("hold20_vector", {busy20, x2_20, x1_20, x0_20}, {1'b1, 3'(k / 20)});
      @(negedge clk);
    end
    chk("hold20_done", {done20, busy20, x2_20, x1_20, x0_20, pass20}, 6'b100001);
    @(negedge clk);
    chk("hold20_after", {done20, busy20, x2_20, x1_20, x0_20}, 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 20, giving the clock cycles each input vector is held (legal range 2..256).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-005 The block SHALL have port expected  input  8  truth table; bit i is the expected y for vector {x2,x1,x0}=i.
REQ-006 The block SHALL have port y  input  1  DUT response under test.
REQ-007 The block SHALL have ports x0, x1, x2  output  1 each  stimulus vector driven to the DUT.
REQ-008 The block SHALL have port busy  output  1  high while a run is in progress.
REQ-009 The block SHALL have port done  output  1  single-cycle pulse at run completion.
REQ-010 The block SHALL have port pass  output  1  high when the last run had zero mismatches.
REQ-011 The block SHALL have port mismatch  output  8  bit i set when vector i failed in the last run.
REQ-012 The block SHALL have port error_count  output  4  number of failed vectors (0..8) in the last run.

Function
REQ-013 The FSM SHALL have states IDLE, APPLY and DONE.
REQ-014 IDLE SHALL drive x2x1x0=000, busy=0 and done=0.
REQ-015 IDLE with start=1 at a clock edge SHALL latch expected, clear mismatch, error_count and pass, set vector index=0 and hold counter=0, and enter APPLY.
REQ-016 APPLY SHALL drive {x2,x1,x0}=index with busy=1.
REQ-017 APPLY SHALL increment the hold counter each cycle.
REQ-018 In the APPLY cycle with hold counter = HOLD_CYCLES-1, the block SHALL sample y and compare it with latched expected[index].
REQ-019 On a compare mismatch, the block SHALL set mismatch[index] and increment error_count at the same edge.
REQ-020 After the compare, if index<7 the block SHALL increment index, clear the hold counter and remain in APPLY.
REQ-021 After the compare, if index=7 the block SHALL enter DONE.
REQ-022 Vectors SHALL be applied in the order 000,001,...,111, each for exactly HOLD_CYCLES cycles, with no gap cycles.
REQ-023 DONE SHALL last exactly one cycle with done=1, busy=0, x2x1x0=000 and pass=(error_count==0), then return to IDLE.
REQ-024 Latency: done SHALL be high in the cycle starting 8*HOLD_CYCLES+1 rising edges after the edge that accepted start.
REQ-025 pass, mismatch and error_count SHALL hold their values from DONE until the next accepted start or reset.
REQ-026 start SHALL be ignored in APPLY and DONE; a start held high continuously SHALL begin a new run on the first IDLE cycle after DONE.
REQ-027 Changes on expected during a run SHALL have no effect; only the value latched at start SHALL be used.
REQ-028 y SHALL be sampled only on compare cycles; y glitches on other cycles SHALL have no effect.
REQ-029 The hold counter SHALL be 8 bits wide and the index 3 bits wide; neither SHALL wrap within a run.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force IDLE with index=0, hold counter=0, x2x1x0=000, busy=0, done=0, pass=0, mismatch=0 and error_count=0.
REQ-031 Reset mid-run SHALL abandon the run with no done pulse; the next accepted start SHALL restart from vector 000.
REQ-032 Reset SHALL take priority over start when both are asserted at the same edge.

Verification
REQ-033 HOLD_CYCLES=4, expected=8'hE8, y modelled as majority(x0,x1,x2) -> done 33 cycles after the start edge, pass=1, mismatch=8'h00, error_count=0.
REQ-034 HOLD_CYCLES=4, expected=8'hE8, y stuck at 0 -> mismatch=8'hE8, error_count=4, pass=0.
REQ-035 HOLD_CYCLES=20, monitor x2x1x0 after start -> 000..111 each held exactly 20 cycles, busy=1 for 160 cycles, x=000 after the run.
REQ-036 Assert rst_n=0 while index=3 -> all outputs 0 at the next edge with no done pulse; the next start runs a full 8-vector sweep from 000.
REQ-037 Hold start=1 throughout and change expected mid-run -> one done every 8*HOLD+2 cycles, each run compared against the expected value latched at its start.
